boot_sequencer: RTL and testbench
=================================

// Module: boot_sequencer
// PURPOSE
//  Boot/run sequencer for the pipelined core; owns instruction-memory port control.
//  After reset, copies BOOT_WORDS words from the bios stream into instruction memory at 0..BOOT_WORDS-1.
//  Holds the register file in reset during the copy, then hands the memory port to the PC and gates PC updates with the HDU stall.
// PARAMETERS
//  ADDR_WIDTH  32  instruction-memory address width
//  DATA_WIDTH  32  instruction word width
//  BOOT_WORDS  5   words copied from bios; legal range 1..2**ADDR_WIDTH-1
// PORTS
//  clock          in   1           system clock, rising edge
//  reset          in   1           synchronous, active-high
//  bios_valid     in   1           bios_data holds a new word this cycle
//  bios_data      in   DATA_WIDTH  bios word
//  pc_address     in   ADDR_WIDTH  PC output, used in RUN
//  hdu_enable     in   1           HDU allows PC update (0 = stall)
//  mem_address    out  ADDR_WIDTH  instruction-memory address
//  mem_data       out  DATA_WIDTH  instruction-memory write data
//  mem_cs         out  1           chip select, active-low
//  mem_we         out  1           write enable
//  mem_oe         out  1           output enable
//  on_bios        out  1           1 while booting
//  reset_regfile  out  1           register-file reset
//  enable_pc      out  1           PC load enable
//  boot_done      out  1           1-cycle pulse on entry to RUN
//  boot_error     out  1           sticky checksum failure (see CONFIGURATION)
// BEHAVIOUR
//  - FSM states: LOAD, FINISH, RUN, ERROR. Reset forces LOAD. Reset mid-operation restarts from word 0.
//  - Reset values:
//    - mem_address=0, mem_data=0, mem_we=0, mem_oe=0, mem_cs=0
//    - on_bios=1, reset_regfile=1, enable_pc=0, boot_done=0, boot_error=0
//    - word counter cnt=0
//  - LOAD:
//    - Each cycle with bios_valid=1, the word is accepted.
//    - Next cycle: mem_we=1, mem_address=cnt, mem_data=bios_data. Write latency is 1 cycle.
//    - cnt then increments. With bios_valid=0, next cycle has mem_we=0 and cnt holds.
//    - When word number BOOT_WORDS-1 is accepted, go to FINISH.
//  - FINISH:
//    - One cycle. The last write (mem_we=1) is presented in this cycle.
//    - Next state is RUN.
//  - RUN:
//    - Registered outputs: mem_we=0, mem_oe=1, on_bios=0, reset_regfile=0.
//    - mem_address=pc_address, combinational passthrough.
//    - enable_pc = hdu_enable, combinational.
//    - boot_done=1 only in the first RUN cycle.
//    - bios_valid is ignored. RUN is left only by reset.
//  - enable_pc=0 in every state other than RUN.
//  - reset_regfile=1 in LOAD, FINISH and ERROR.
//  - cnt is ADDR_WIDTH bits wide and never wraps, because the BOOT_WORDS limit prevents it.
//  - A bios word arriving in the same cycle as reset is dropped.
// CONFIGURATION
//  BOOT_CHECKSUM_EN defined:
//    - LOAD accepts BOOT_WORDS+1 words.
//    - The final word is not written to memory. It is compared with the 32-bit wrapping sum of the BOOT_WORDS data words.
//    - Match: FINISH, then RUN as normal.
//    - Mismatch: ERROR. In ERROR, boot_error=1, on_bios=1, mem_we=0, enable_pc=0. Held until reset.
//  BOOT_CHECKSUM_EN undefined:
//    - No checksum word is consumed. No accumulator logic is built.
//    - ERROR is unreachable. boot_error is tied to 0.
// TESTING
//  1. Reset, then bios_valid=1 for 5 cycles with data 0x11..0x55.
//     -> mem_we pulses at addr 0..4 with those words; first RUN cycle shows boot_done=1, on_bios=0, reset_regfile=0.
//  2. In LOAD, drive bios_valid 1,0,0,1 with words 0xA,0xB.
//     -> writes at addr 0 then addr 1 only; cnt=2; no mem_we in the gap cycles.
//  3. In RUN, pc_address=0x7, hdu_enable=0 then 1.
//     -> mem_address=0x7, mem_oe=1; enable_pc follows 0 then 1.
//  4. Reset asserted after 3 words are written.
//     -> next cycle all outputs at reset values; the following boot writes start again at addr 0.
//  5. BOOT_CHECKSUM_EN, words 1,2,3,4,5, checksum 15.
//     -> RUN reached, boot_error=0, addr 5 never written.
//     Same words with checksum 16 -> ERROR, boot_error=1, enable_pc stays 0.
//  6. With BOOT_WORDS=1, one word 0xDEAD.
//     -> single write at addr 0, then FINISH, then RUN; boot_done is asserted exactly once.

Source files
------------

// File: rtl/boot_sequencer.sv
// Boot/run sequencer: copies BOOT_WORDS bios words into instruction memory, then hands the port to the PC.
// Optional build macro BOOT_CHECKSUM_EN adds a trailing checksum word and the sticky ERROR state.
module boot_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BOOT_WORDS = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  bios_valid,
    input  logic [DATA_WIDTH-1:0] bios_data,
    input  logic [ADDR_WIDTH-1:0] pc_address,
    input  logic                  hdu_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic                  on_bios,
    output logic                  reset_regfile,
    output logic                  enable_pc,
    output logic                  boot_done,
    output logic                  boot_error
);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_FINISH = 2'd1,
        S_RUN    = 2'd2,
        S_ERROR  = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
    logic                  r_we, w_we_nxt;
    logic                  r_oe, w_oe_nxt;
    logic                  r_on_bios, w_on_bios_nxt;
    logic                  r_rst_rf, w_rst_rf_nxt;
    logic                  r_done, w_done_nxt;

`ifdef BOOT_CHECKSUM_EN
    localparam logic [ADDR_WIDTH-1:0] CNT_CHK = ADDR_WIDTH'(BOOT_WORDS);
    logic [DATA_WIDTH-1:0] r_sum, w_sum_nxt;
    logic                  r_err, w_err_nxt;
`else
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(BOOT_WORDS - 1);
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_addr_nxt    = r_addr;
        w_data_nxt    = r_data;
        w_we_nxt      = 1'b0;
        w_oe_nxt      = r_oe;
        w_on_bios_nxt = r_on_bios;
        w_rst_rf_nxt  = r_rst_rf;
        w_done_nxt    = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        w_sum_nxt     = r_sum;
        w_err_nxt     = r_err;
`endif
        unique case (r_state)
            S_LOAD: begin
                if (bios_valid) begin
`ifdef BOOT_CHECKSUM_EN
                    // The word after the last data word is the checksum; it is never written.
                    if (r_cnt == CNT_CHK) begin
                        if (bios_data == r_sum) begin
                            w_state_nxt = S_FINISH;
                        end else begin
                            w_state_nxt = S_ERROR;
                            w_err_nxt   = 1'b1;
                        end
                    end else begin
                        w_we_nxt   = 1'b1;
                        w_addr_nxt = r_cnt;
                        w_data_nxt = bios_data;
                        w_cnt_nxt  = r_cnt + ADDR_WIDTH'(1);
                        w_sum_nxt  = r_sum + bios_data;
                    end
`else
                    w_we_nxt   = 1'b1;
                    w_addr_nxt = r_cnt;
                    w_data_nxt = bios_data;
                    w_cnt_nxt  = r_cnt + ADDR_WIDTH'(1);
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = S_FINISH;
                    end
`endif
                end
            end
            S_FINISH: begin
                w_state_nxt   = S_RUN;
                w_oe_nxt      = 1'b1;
                w_on_bios_nxt = 1'b0;
                w_rst_rf_nxt  = 1'b0;
                w_done_nxt    = 1'b1;
            end
            S_RUN: begin
            end
            S_ERROR: begin
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_LOAD;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_we      <= 1'b0;
            r_oe      <= 1'b0;
            r_on_bios <= 1'b1;
            r_rst_rf  <= 1'b1;
            r_done    <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            r_sum     <= '0;
            r_err     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_addr    <= w_addr_nxt;
            r_data    <= w_data_nxt;
            r_we      <= w_we_nxt;
            r_oe      <= w_oe_nxt;
            r_on_bios <= w_on_bios_nxt;
            r_rst_rf  <= w_rst_rf_nxt;
            r_done    <= w_done_nxt;
`ifdef BOOT_CHECKSUM_EN
            r_sum     <= w_sum_nxt;
            r_err     <= w_err_nxt;
`endif
        end
    end

    // In RUN the PC owns the address and the HDU gates PC loads without a register stage.
    assign mem_address   = (r_state == S_RUN) ? pc_address : r_addr;
    assign enable_pc     = (r_state == S_RUN) && hdu_enable;
    assign mem_data      = r_data;
    assign mem_cs        = 1'b0;
    assign mem_we        = r_we;
    assign mem_oe        = r_oe;
    assign on_bios       = r_on_bios;
    assign reset_regfile = r_rst_rf;
    assign boot_done     = r_done;
`ifdef BOOT_CHECKSUM_EN
    assign boot_error    = r_err;
`else
    assign boot_error    = 1'b0;
`endif

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer (BOOT_WORDS=5 instance plus a BOOT_WORDS=1 instance).
// Checksum-specific steps are compiled in when BOOT_CHECKSUM_EN is defined.
module tb_boot_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        bios_valid, b1_valid;
    logic [31:0] bios_data, b1_data;
    logic [31:0] pc_address;
    logic        hdu_enable;

    logic [31:0] mem_address, mem_data;
    logic        mem_cs, mem_we, mem_oe, on_bios, reset_regfile, enable_pc, boot_done, boot_error;
    logic [31:0] b1_address, b1_mdata;
    logic        b1_cs, b1_we, b1_oe, b1_on_bios, b1_rst_rf, b1_en_pc, b1_done, b1_error;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    boot_sequencer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BOOT_WORDS(5)) dut (
        .clock(clock), .reset(reset), .bios_valid(bios_valid), .bios_data(bios_data),
        .pc_address(pc_address), .hdu_enable(hdu_enable),
        .mem_address(mem_address), .mem_data(mem_data), .mem_cs(mem_cs), .mem_we(mem_we),
        .mem_oe(mem_oe), .on_bios(on_bios), .reset_regfile(reset_regfile),
        .enable_pc(enable_pc), .boot_done(boot_done), .boot_error(boot_error)
    );

    boot_sequencer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BOOT_WORDS(1)) dut1 (
        .clock(clock), .reset(reset), .bios_valid(b1_valid), .bios_data(b1_data),
        .pc_address(pc_address), .hdu_enable(hdu_enable),
        .mem_address(b1_address), .mem_data(b1_mdata), .mem_cs(b1_cs), .mem_we(b1_we),
        .mem_oe(b1_oe), .on_bios(b1_on_bios), .reset_regfile(b1_rst_rf),
        .enable_pc(b1_en_pc), .boot_done(b1_done), .boot_error(b1_error)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bios_valid = 1'b0;
        b1_valid = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"}, mem_address, 0);
        chk({tag, "_data"}, mem_data, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_oe"}, mem_oe, 0);
        chk({tag, "_cs"}, mem_cs, 0);
        chk({tag, "_on_bios"}, on_bios, 1);
        chk({tag, "_rst_rf"}, reset_regfile, 1);
        chk({tag, "_en_pc"}, enable_pc, 0);
        chk({tag, "_done"}, boot_done, 0);
        chk({tag, "_err"}, boot_error, 0);
    endtask

    initial begin
        reset = 1'b0; bios_valid = 1'b0; bios_data = '0; b1_valid = 1'b0; b1_data = '0;
        pc_address = '0; hdu_enable = 1'b1;

        // Test 1: reset state, then five words 0x11..0x55
        do_reset();
        chk_reset_vals("t1_rst");
        for (int i = 0; i < 5; i++) begin
            bios_valid = 1'b1;
            bios_data = 32'h11 * (i + 1);
            step();
            chk($sformatf("t1_we%0d", i), mem_we, 1);
            chk($sformatf("t1_addr%0d", i), mem_address, i);
            chk($sformatf("t1_data%0d", i), mem_data, 32'h11 * (i + 1));
            chk($sformatf("t1_en_pc%0d", i), enable_pc, 0);
            chk($sformatf("t1_done%0d", i), boot_done, 0);
        end
`ifdef BOOT_CHECKSUM_EN
        bios_valid = 1'b1; bios_data = 32'hFF;
        step();
        chk("t1_chk_nowrite", mem_we, 0);
`endif
        bios_valid = 1'b0;
        step();
        chk("t1_run_done", boot_done, 1);
        chk("t1_run_on_bios", on_bios, 0);
        chk("t1_run_rst_rf", reset_regfile, 0);
        chk("t1_run_we", mem_we, 0);
        chk("t1_run_oe", mem_oe, 1);
        chk("t1_run_err", boot_error, 0);
        step();
        chk("t1_done_pulse", boot_done, 0);

        // Test 3: RUN passthroughs; bios traffic ignored
        pc_address = 32'h7; hdu_enable = 1'b0; bios_valid = 1'b1; bios_data = 32'h99;
        #1;
        chk("t3_addr", mem_address, 32'h7);
        chk("t3_oe", mem_oe, 1);
        chk("t3_en_stall", enable_pc, 0);
        hdu_enable = 1'b1;
        #1;
        chk("t3_en_go", enable_pc, 1);
        step();
        chk("t3_ignore_we", mem_we, 0);
        chk("t3_ignore_done", boot_done, 0);
        bios_valid = 1'b0;

        // Test 2: gapped bios stream
        do_reset();
        chk_reset_vals("t2_rst");
        bios_valid = 1'b1; bios_data = 32'hA;
        step();
        chk("t2_we0", mem_we, 1);
        chk("t2_addr0", mem_address, 0);
        chk("t2_data0", mem_data, 32'hA);
        bios_valid = 1'b0;
        step();
        chk("t2_gap1", mem_we, 0);
        step();
        chk("t2_gap2", mem_we, 0);
        bios_valid = 1'b1; bios_data = 32'hB;
        step();
        chk("t2_we1", mem_we, 1);
        chk("t2_addr1", mem_address, 1);
        chk("t2_data1", mem_data, 32'hB);
        bios_data = 32'hC;
        step();
        chk("t2_cnt2_addr", mem_address, 2);
        chk("t2_cnt2_data", mem_data, 32'hC);
        bios_valid = 1'b0;

        // Test 4: reset after three writes, word during reset dropped
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bios_valid = 1'b1; bios_data = 32'h100 + i;
            step();
            chk($sformatf("t4_addr%0d", i), mem_address, i);
        end
        reset = 1'b1; bios_valid = 1'b1; bios_data = 32'h5A5A;
        step();
        reset = 1'b0; bios_valid = 1'b0;
        chk_reset_vals("t4_rst");
        step();
        chk("t4_dropped", mem_we, 0);
        bios_valid = 1'b1; bios_data = 32'h77;
        step();
        chk("t4_restart_we", mem_we, 1);
        chk("t4_restart_addr", mem_address, 0);
        chk("t4_restart_data", mem_data, 32'h77);
        bios_valid = 1'b0;

        // Test 6: BOOT_WORDS=1 instance
        do_reset();
        b1_valid = 1'b1; b1_data = 32'hDEAD;
        step();
        chk("t6_we", b1_we, 1);
        chk("t6_addr", b1_address, 0);
        chk("t6_data", b1_mdata, 32'hDEAD);
        chk("t6_done_early", b1_done, 0);
`ifdef BOOT_CHECKSUM_EN
        b1_data = 32'hDEAD;
        step();
        chk("t6_chk_nowrite", b1_we, 0);
`endif
        b1_valid = 1'b0;
        step();
        chk("t6_done", b1_done, 1);
        chk("t6_we_off", b1_we, 0);
        chk("t6_on_bios", b1_on_bios, 0);
        step();
        chk("t6_done_once", b1_done, 0);
        step();
        chk("t6_done_stays", b1_done, 0);
        chk("t6_en_pc", b1_en_pc, 1);

`ifdef BOOT_CHECKSUM_EN
        // Test 5: checksum match, then mismatch
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            bios_valid = 1'b1; bios_data = i;
            step();
            chk($sformatf("t5_addr%0d", i), mem_address, i - 1);
        end
        bios_data = 32'd15;
        step();
        chk("t5_no_addr5", mem_we, 0);
        bios_valid = 1'b0;
        step();
        chk("t5_done", boot_done, 1);
        chk("t5_err", boot_error, 0);
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            bios_valid = 1'b1; bios_data = i;
            step();
        end
        bios_data = 32'd16;
        step();
        bios_valid = 1'b0; hdu_enable = 1'b1;
        chk("t5_bad_err", boot_error, 1);
        chk("t5_bad_on_bios", on_bios, 1);
        chk("t5_bad_we", mem_we, 0);
        chk("t5_bad_en_pc", enable_pc, 0);
        step();
        chk("t5_bad_sticky", boot_error, 1);
        chk("t5_bad_no_done", boot_done, 0);
        chk("t5_bad_en_pc2", enable_pc, 0);
`else
        chk("t5_err_tied", boot_error, 0);
        chk("t5_err_tied1", b1_error, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
